// File: rtl/pipe_stage_elastic_if.sv
// Handshake bundle between an upstream stage, the elastic stage register and a downstream stage.
// valid/ready: a beat transfers on a rising edge where valid and ready are both 1; valid-side signals must not change while valid=1 and ready=0.
interface pipe_stage_elastic_if #(
  parameter int CTRL_W = 22,
  parameter int DATA_W = 160
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // The environment around the stage: feeds the input side, consumes the output side.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  // The stage register itself.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: 2-entry skid buffer with registered in_ready,
// synchronous flush, bubble zeroing of control and a saturating stall counter.
module pipe_stage_elastic #(
  parameter int CTRL_W = 22,
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_elastic_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_d     = stall_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_d = stall_q + 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
            state_d     = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (push) begin
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
            state_d     = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            state_d     = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign bus.out_data  = main_data_q;
  assign occupancy     = state_q;
  assign stall_count   = stall_q;

endmodule
